fifo_write_arbiter: RTL and testbench

//  Shares the write port of one FIFO (e.g. fifo_async_sv in-side) between N_REQ producers.

---
 rtl/fifo_write_arbiter_if.sv | 27 ++
 rtl/fifo_write_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between the write arbiter, its producers and the FIFO write port.
// The master side is the arbiter. The slave side is the environment, meaning the producers plus the FIFO.
interface fifo_write_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       req_enable;
   logic [N_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]       fifo_data;
   logic                   fifo_enable;
   logic                   fifo_ready;
   logic                   grant_valid;
   logic [IDW-1:0]         grant_id;

   modport master (
      input  req_data, req_enable, fifo_ready,
      output req_ready, fifo_data, fifo_enable, grant_valid, grant_id
   );

   modport slave (
      output req_data, req_enable, fifo_ready,
      input  req_ready, fifo_data, fifo_enable, grant_valid, grant_id
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// When a requester wins, it holds the port until one of two things happens:
//   - it has moved MAX_BURST words, or
//   - it drops enable.
// After every grant there is one IDLE arbitration cycle.
module fifo_write_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 16
) (
   input logic                  i_clk,
   input logic                  i_reset,
   fifo_write_arbiter_if.master bus
);
   localparam int IDW = $clog2(N_REQ);
   localparam int BCW = $clog2(MAX_BURST + 1);
   localparam logic [IDW-1:0] LAST_IDX  = IDW'(N_REQ - 1);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_grantValid;
   logic [IDW-1:0]   r_grantId;
   logic [IDW-1:0]   r_rrPtr;
   logic [BCW-1:0]   r_burstCnt;

   logic [WIDTH-1:0] w_reqWords [N_REQ];
   logic             w_anyReq;
   logic [IDW-1:0]   w_winner;
   logic [IDW-1:0]   w_scanIdx;
   logic             w_active;
   logic             w_ownerEnable;
   logic             w_transfer;
   logic             w_lastBeat;
   logic [WIDTH-1:0] w_fifoData;
   logic             w_fifoEnable;
   logic [N_REQ-1:0] w_reqReady;

   // Unpack the flat requester data bus into one word per requester.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         w_reqWords[i] = bus.req_data[i*WIDTH +: WIDTH];
      end
   end

   // Pick the first enabled requester after the last winner, wrapping around.
   // When rr_ptr sits at the top index, requester 0 is checked first.
   always_comb begin
      w_anyReq  = 1'b0;
      w_winner  = '0;
      w_scanIdx = r_rrPtr;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_scanIdx == LAST_IDX) begin
            w_scanIdx = '0;
         end else begin
            w_scanIdx = w_scanIdx + 1'b1;
         end
         if (!w_anyReq && bus.req_enable[w_scanIdx]) begin
            w_anyReq = 1'b1;
            w_winner = w_scanIdx;
         end
      end
   end

   // Pass the owner's handshake through to the FIFO and return the FIFO's ready to the owner only.
   // Reset gates the path so that no word can move while reset is held.
   always_comb begin
      w_active      = (r_state == GRANT) && !i_reset;
      w_ownerEnable = bus.req_enable[r_grantId];
      w_fifoData    = '0;
      w_fifoEnable  = 1'b0;
      w_reqReady    = '0;
      if (w_active) begin
         w_fifoData            = w_reqWords[r_grantId];
         w_fifoEnable          = w_ownerEnable;
         w_reqReady[r_grantId] = bus.fifo_ready;
      end
      w_transfer = w_active && w_ownerEnable && bus.fifo_ready;
      w_lastBeat = (r_burstCnt == LAST_BEAT);
   end

   // Grant state machine.
   // rr_ptr only moves on a grant.
   // The burst counter only advances on an actual transfer, so a stalled FIFO freezes it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_grantValid <= 1'b0;
         r_grantId    <= '0;
         r_burstCnt   <= '0;
         r_rrPtr      <= LAST_IDX;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_state      <= GRANT;
                  r_grantValid <= 1'b1;
                  r_grantId    <= w_winner;
                  r_rrPtr      <= w_winner;
                  r_burstCnt   <= '0;
               end
            end
            GRANT: begin
               if (!w_ownerEnable) begin
                  r_state      <= IDLE;
                  r_grantValid <= 1'b0;
                  r_burstCnt   <= '0;
               end else if (w_transfer) begin
                  if (w_lastBeat) begin
                     r_state      <= IDLE;
                     r_grantValid <= 1'b0;
                     r_burstCnt   <= '0;
                  end else begin
                     r_burstCnt <= r_burstCnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state      <= IDLE;
               r_grantValid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fifo_data   = w_fifoData;
   assign bus.fifo_enable = w_fifoEnable;
   assign bus.req_ready   = w_reqReady;
   assign bus.grant_valid = r_grantValid;
   assign bus.grant_id    = r_grantId;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomised bench for fifo_write_arbiter.
// It drives two instances:
//   - dutA: 4 requesters, bursts of 16.
//   - dutB: 3 requesters, bursts of 1.
// Producers and the FIFO are modelled inside the bench.
module tb_fifo_write_arbiter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) ifA ();
   fifo_write_arbiter_if #(.N_REQ(3), .WIDTH(8)) ifB ();

   fifo_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(16)) dutA (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (ifA)
   );

   fifo_write_arbiter #(.N_REQ(3), .WIDTH(8), .MAX_BURST(1)) dutB (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (ifB)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   // dutA producer and scoreboard state
   logic [3:0] actA;
   logic       fifoReadyA;
   int         limA [4];
   int         cntA [4];
   logic [7:0] expA [$];
   int         grantLogA [$];
   int         burstLensA [$];
   int         curLenA;
   logic       prevGvA;
   int         cycleNo;
   int         firstXferA;
   int         lastXferA;

   // dutB producer and scoreboard state
   logic       runB;
   logic       drainB;
   logic [2:0] pendB;
   int         cntB [3];
   logic [7:0] qB0 [$];
   logic [7:0] qB1 [$];
   logic [7:0] qB2 [$];
   logic       prevXferB;
   int         xferCountB;

   function automatic logic [7:0] mkWord(input int id, input int n);
      logic [7:0] w;
      w = {id[1:0], n[5:0]};
      return w;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic pushB(input int id, input logic [7:0] w);
      case (id)
         0:       qB0.push_back(w);
         1:       qB1.push_back(w);
         default: qB2.push_back(w);
      endcase
   endtask

   task automatic popB(input int id, output logic [7:0] w, output logic ok);
      w  = '0;
      ok = 1'b0;
      case (id)
         0: if (qB0.size() > 0) begin w = qB0.pop_front(); ok = 1'b1; end
         1: if (qB1.size() > 0) begin w = qB1.pop_front(); ok = 1'b1; end
         2: if (qB2.size() > 0) begin w = qB2.pop_front(); ok = 1'b1; end
         default: ok = 1'b0;
      endcase
   endtask

   task automatic resetCountersA();
      for (int i = 0; i < 4; i++) begin
         cntA[i] = 0;
         limA[i] = 0;
      end
      expA.delete();
      grantLogA.delete();
      burstLensA.delete();
      curLenA = 0;
   endtask

   // One clock cycle: drive both DUTs, sample at negedge, then step past the posedge.
   task automatic applyStimulus();
      logic [3:0]  enA;
      logic [31:0] dataA;
      logic [23:0] dataB;
      logic [3:0]  accA;
      logic [2:0]  accB;
      logic [3:0]  allowA;
      logic [2:0]  allowB;
      logic        xferB;
      logic [7:0]  w;
      logic        ok;
      int          owner;

      enA   = '0;
      dataA = '0;
      for (int i = 0; i < 4; i++) begin
         if (actA[i] && cntA[i] < limA[i]) begin
            enA[i]           = 1'b1;
            dataA[i*8 +: 8]  = mkWord(i, cntA[i]);
         end
      end
      ifA.req_enable = enA;
      ifA.req_data   = dataA;
      ifA.fifo_ready = fifoReadyA;

      dataB = '0;
      for (int i = 0; i < 3; i++) begin
         if (runB && !drainB && !pendB[i] && ($urandom_range(0, 99) < 50)) begin
            pendB[i] = 1'b1;
            pushB(i, mkWord(i, cntB[i]));
         end
         if (pendB[i]) dataB[i*8 +: 8] = mkWord(i, cntB[i]);
      end
      ifB.req_enable = pendB;
      ifB.req_data   = dataB;
      ifB.fifo_ready = runB ? (drainB ? 1'b1 : ($urandom_range(0, 99) < 60)) : 1'b0;

      @(negedge clk);

      allowA = (ifA.grant_valid && ifA.fifo_ready) ? (4'b0001 << ifA.grant_id) : 4'b0000;
      checkOutput("A.readyLegal",
                  {27'd0, (!ifA.grant_valid && ifA.fifo_enable), ifA.req_ready & ~allowA}, 32'd0);
      if (ifA.fifo_enable && ifA.fifo_ready) begin
         checkOutput("A.wordExpected", {31'd0, expA.size() > 0}, 32'd1);
         if (expA.size() > 0) begin
            w = expA.pop_front();
            checkOutput("A.data", {24'd0, ifA.fifo_data}, {24'd0, w});
         end
         curLenA++;
         if (firstXferA < 0) firstXferA = cycleNo;
         lastXferA = cycleNo;
      end
      accA = ifA.req_ready & ifA.req_enable;
      for (int i = 0; i < 4; i++) if (accA[i]) cntA[i]++;
      if (ifA.grant_valid && !prevGvA) grantLogA.push_back(int'(ifA.grant_id));
      if (!ifA.grant_valid && prevGvA) begin
         burstLensA.push_back(curLenA);
         curLenA = 0;
      end
      prevGvA = ifA.grant_valid;

      allowB = (ifB.grant_valid && ifB.fifo_ready) ? (3'b001 << ifB.grant_id) : 3'b000;
      checkOutput("B.readyLegal",
                  {28'd0, (!ifB.grant_valid && ifB.fifo_enable), ifB.req_ready & ~allowB}, 32'd0);
      if (prevXferB) checkOutput("B.bubbleAfterWord", {31'd0, ifB.grant_valid}, 32'd0);
      xferB = ifB.fifo_enable && ifB.fifo_ready;
      if (xferB) begin
         owner = int'(ifB.grant_id);
         checkOutput("B.ownerAccepts", {31'd0, ifB.req_ready[owner] & ifB.req_enable[owner]}, 32'd1);
         popB(owner, w, ok);
         checkOutput("B.wordQueued", {31'd0, ok}, 32'd1);
         if (ok) checkOutput("B.data", {24'd0, ifB.fifo_data}, {24'd0, w});
         xferCountB++;
      end
      accB = ifB.req_ready & ifB.req_enable;
      for (int i = 0; i < 3; i++) begin
         if (accB[i]) begin
            pendB[i] = 1'b0;
            cntB[i]++;
         end
      end
      prevXferB = xferB;
      cycleNo++;

      @(posedge clk);
      #1;
   endtask

   initial begin
      int expGrants [5];
      int expLens [3];

      reset      = 1'b1;
      actA       = '0;
      fifoReadyA = 1'b0;
      resetCountersA();
      prevGvA    = 1'b0;
      cycleNo    = 0;
      firstXferA = -1;
      lastXferA  = -1;
      runB       = 1'b0;
      drainB     = 1'b0;
      pendB      = '0;
      for (int i = 0; i < 3; i++) cntB[i] = 0;
      prevXferB  = 1'b0;
      xferCountB = 0;

      // Test 1: reset with no requests, then reset with every requester asking.
      for (int c = 0; c < 10; c++) applyStimulus();
      checkOutput("T1.grantValid", {31'd0, ifA.grant_valid}, 32'd0);
      checkOutput("T1.grantId", {30'd0, ifA.grant_id}, 32'd0);
      checkOutput("T1.fifoEnable", {31'd0, ifA.fifo_enable}, 32'd0);
      checkOutput("T1.reqReady", {28'd0, ifA.req_ready}, 32'd0);
      limA[0] = 32;
      limA[1] = 16;
      limA[2] = 16;
      limA[3] = 16;
      actA       = 4'b1111;
      fifoReadyA = 1'b1;
      for (int c = 0; c < 2; c++) applyStimulus();
      checkOutput("T1.quietInReset", {27'd0, ifA.grant_valid, ifA.fifo_enable, ifA.req_ready}, 32'd0);

      // Test 2: full contention. Expect grants 0,1,2,3,0, 16 words each, with one bubble in between.
      for (int r = 0; r < 4; r++) for (int k = 0; k < 16; k++) expA.push_back(mkWord(r, k));
      for (int k = 16; k < 32; k++) expA.push_back(mkWord(0, k));
      reset   = 1'b0;
      cycleNo = 0;
      for (int c = 0; c < 300 && expA.size() > 0; c++) applyStimulus();
      for (int c = 0; c < 3; c++) applyStimulus();
      checkOutput("T2.allWordsSeen", expA.size(), 32'd0);
      checkOutput("T2.firstXferCycle", firstXferA, 32'd1);
      checkOutput("T2.span", lastXferA - firstXferA, 32'd83);
      checkOutput("T2.grantCount", grantLogA.size(), 32'd5);
      expGrants = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         if (i < grantLogA.size()) checkOutput("T2.grantOrder", grantLogA[i], expGrants[i]);
         if (i < burstLensA.size()) checkOutput("T2.burstLen", burstLensA[i], 32'd16);
      end

      // Test 3: requester 2 sends 5 words and drops enable; then 3 beats 0 because rr_ptr is 2.
      resetCountersA();
      actA    = 4'b0100;
      limA[2] = 5;
      for (int k = 0; k < 5; k++) expA.push_back(mkWord(2, k));
      for (int c = 0; c < 50 && expA.size() > 0; c++) applyStimulus();
      checkOutput("T3.heldUntilDrop", {31'd0, ifA.grant_valid}, 32'd1);
      applyStimulus();
      checkOutput("T3.releasedAfterDrop", {31'd0, ifA.grant_valid}, 32'd0);
      actA    = 4'b1001;
      limA[0] = 1;
      limA[3] = 1;
      expA.push_back(mkWord(3, 0));
      expA.push_back(mkWord(0, 0));
      for (int c = 0; c < 50 && expA.size() > 0; c++) applyStimulus();
      for (int c = 0; c < 3; c++) applyStimulus();
      checkOutput("T3.allWordsSeen", expA.size(), 32'd0);
      checkOutput("T3.grantCount", grantLogA.size(), 32'd3);
      expGrants = '{2, 3, 0, 0, 0};
      expLens   = '{5, 1, 1};
      for (int i = 0; i < 3; i++) begin
         if (i < grantLogA.size()) checkOutput("T3.grantOrder", grantLogA[i], expGrants[i]);
         if (i < burstLensA.size()) checkOutput("T3.burstLen", burstLensA[i], expLens[i]);
      end

      // Test 4: the FIFO stalls for 20 cycles during requester 1's burst.
      resetCountersA();
      actA    = 4'b0010;
      limA[1] = 20;
      for (int k = 0; k < 20; k++) expA.push_back(mkWord(1, k));
      for (int c = 0; c < 30 && cntA[1] < 4; c++) applyStimulus();
      fifoReadyA = 1'b0;
      for (int c = 0; c < 20; c++) applyStimulus();
      checkOutput("T4.stallHoldsGrant", {29'd0, ifA.grant_valid, ifA.grant_id}, {29'd0, 1'b1, 2'd1});
      checkOutput("T4.stallNoReady", {28'd0, ifA.req_ready}, 32'd0);
      checkOutput("T4.stallNoWords", cntA[1], 32'd4);
      fifoReadyA = 1'b1;
      for (int c = 0; c < 80 && expA.size() > 0; c++) applyStimulus();
      for (int c = 0; c < 3; c++) applyStimulus();
      checkOutput("T4.allWordsSeen", expA.size(), 32'd0);
      checkOutput("T4.grantCount", grantLogA.size(), 32'd2);
      expLens = '{16, 4, 0};
      for (int i = 0; i < 2; i++) begin
         if (i < grantLogA.size()) checkOutput("T4.grantOrder", grantLogA[i], 32'd1);
         if (i < burstLensA.size()) checkOutput("T4.burstLen", burstLensA[i], expLens[i]);
      end

      // Test 5: a reset pulse arrives while requester 3 is presenting word 7.
      resetCountersA();
      actA    = 4'b1000;
      limA[3] = 10;
      limA[1] = 3;
      for (int k = 0; k < 7; k++) expA.push_back(mkWord(3, k));
      for (int k = 0; k < 3; k++) expA.push_back(mkWord(1, k));
      for (int k = 7; k < 10; k++) expA.push_back(mkWord(3, k));
      for (int c = 0; c < 30 && cntA[3] < 7; c++) applyStimulus();
      reset = 1'b1;
      actA  = 4'b1010;
      applyStimulus();
      checkOutput("T5.noXferInReset", cntA[3], 32'd7);
      checkOutput("T5.idleAfterReset", {29'd0, ifA.grant_valid, ifA.grant_id}, 32'd0);
      reset = 1'b0;
      for (int c = 0; c < 80 && expA.size() > 0; c++) applyStimulus();
      for (int c = 0; c < 3; c++) applyStimulus();
      checkOutput("T5.allWordsSeen", expA.size(), 32'd0);
      checkOutput("T5.grantCount", grantLogA.size(), 32'd3);
      expGrants = '{3, 1, 3, 0, 0};
      expLens   = '{7, 3, 3};
      for (int i = 0; i < 3; i++) begin
         if (i < grantLogA.size()) checkOutput("T5.grantOrder", grantLogA[i], expGrants[i]);
         if (i < burstLensA.size()) checkOutput("T5.burstLen", burstLensA[i], expLens[i]);
      end

      // Test 6: random enables and FIFO ready on the 3-requester, single-word-burst instance.
      actA = '0;
      runB = 1'b1;
      for (int c = 0; c < 400; c++) applyStimulus();
      drainB = 1'b1;
      for (int c = 0; c < 100 && pendB != 3'b000; c++) applyStimulus();
      for (int c = 0; c < 2; c++) applyStimulus();
      checkOutput("T6.drained", {29'd0, pendB}, 32'd0);
      checkOutput("T6.queue0Empty", qB0.size(), 32'd0);
      checkOutput("T6.queue1Empty", qB1.size(), 32'd0);
      checkOutput("T6.queue2Empty", qB2.size(), 32'd0);
      checkOutput("T6.traffic", {31'd0, xferCountB > 20}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
